// File: rtl/disp7s_scan_pkg.sv
// disp7s_scan_pkg: shared FSM states, segment table and width helpers for the display scanner
package disp7s_scan_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;
    // Segment patterns a..g (bit6..bit0), entry n is hex digit n
    localparam logic [15:0][6:0] SEG_TAB = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/disp7s_scan_if.sv
// disp7s_scan_if: control/data inputs and display outputs of the scanner
//   master: drives en, load, data, blank_lz; observes seg, dig_en, frame_done, busy
//   slave : the scanner side
interface disp7s_scan_if #(parameter int NDIG = 4);
    logic              en;
    logic              load;
    logic [4*NDIG-1:0] data;
    logic              blank_lz;
    logic [6:0]        seg;
    logic [NDIG-1:0]   dig_en;
    logic              frame_done;
    logic              busy;
    modport master(output en, load, data, blank_lz, input seg, dig_en, frame_done, busy);
    modport slave(input en, load, data, blank_lz, output seg, dig_en, frame_done, busy);
endinterface

// File: rtl/disp7s.sv
// disp7s: hex nibble to 7-segment pattern (nib in, seg out, active-high, bit6=a .. bit0=g)
module disp7s
    import disp7s_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_TAB[nib];
endmodule

// File: rtl/disp7s_scan.sv
// disp7s_scan: multiplexed NDIG-digit 7-segment scanner with frame-synchronous update
//   clk, rst_n : clock, async active-low reset
//   bus        : en/load/data/blank_lz in; seg/dig_en/frame_done/busy out (all registered)
module disp7s_scan
    import disp7s_scan_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int DIV  = 50000,
    parameter int GAP  = 2
)
(
    input  logic          clk,
    input  logic          rst_n,
    disp7s_scan_if.slave  bus
);
    localparam int IW = width_of(NDIG);
    localparam int PW = width_of(DIV);

    state_t            state, state_n;
    logic [PW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic [4*NDIG-1:0] disp, pend;
    logic [3:0]        nib;
    logic [6:0]        dec, seg_n;
    logic [NDIG-1:0]   dig_n;
    logic              slot_end, frame_end, commit, blank, on;

    assign slot_end  = state == ST_GAP && cnt == PW'(DIV - 1);
    assign frame_end = bus.en && slot_end && idx == IW'(NDIG - 1);
    // Display register only changes at a frame boundary or when scanning starts
    assign commit    = bus.en && (state == ST_IDLE || frame_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = !bus.en ? ST_IDLE :
                  state == ST_IDLE ? ST_SHOW :
                  state == ST_SHOW ? (cnt == PW'(DIV - GAP - 1) ? ST_GAP : ST_SHOW) :
                  slot_end ? ST_SHOW : ST_GAP;
        cnt_n   = (state_n == ST_IDLE || state == ST_IDLE || cnt == PW'(DIV - 1)) ? '0 : cnt + 1'b1;
        idx_n   = state_n == ST_IDLE ? '0 :
                  slot_end ? (idx == IW'(NDIG - 1) ? '0 : idx + 1'b1) : idx;
    end

    disp7s u_dec (.nib(nib), .seg(dec));

    // Outputs are computed from the current state and registered, so they lag it by one cycle
    always_comb begin
        nib   = disp[{idx, 2'b00} +: 4];
        blank = bus.blank_lz && idx != '0 && (disp >> {idx, 2'b00}) == '0;
        on    = state == ST_SHOW && bus.en;
        seg_n = (on && !blank) ? dec : '0;
        dig_n = on ? NDIG'(1) << idx : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend           <= '0;
            disp           <= '0;
            bus.busy       <= 1'b0;
            bus.seg        <= '0;
            bus.dig_en     <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            if (bus.load)
                pend <= bus.data;
            // A load coinciding with a commit bypasses pending and goes straight to display
            if (commit)
                disp <= bus.load ? bus.data : pend;
            bus.busy       <= commit ? 1'b0 : (bus.load | bus.busy);
            bus.seg        <= seg_n;
            bus.dig_en     <= dig_n;
            bus.frame_done <= frame_end;
        end
    end
endmodule

// File: doc/disp7s_scan.md
DISP7S_SCAN -- requirements
Module: disp7s_scan

Interface
REQ-001 Parameter NDIG, default 4: number of multiplexed digits (2..8).
REQ-002 Parameter DIV, default 50000: clk cycles per digit slot, SHOW plus GAP (>= GAP+2).
REQ-003 Parameter GAP, default 2: anti-ghosting cycles with all digits off at the end of each slot (>= 1).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  scanning enable; 0 forces all digits off.
REQ-007 load  input  1  one-cycle strobe; capture data into pending register.
REQ-008 data  input  4*NDIG  hex nibbles; nibble i (bits 4i+3..4i) drives digit i; digit 0 is least significant.
REQ-009 blank_lz  input  1  1 = leading-zero blanking on.
REQ-010 seg  output  7  registered segment drive, active-high, bit6=a .. bit0=g.
REQ-011 dig_en  output  NDIG  registered one-hot digit enable, active-high.
REQ-012 frame_done  output  1  one-cycle pulse when the last digit slot of a frame ends.
REQ-013 busy  output  1  high while a loaded value is pending and not yet displayed.

Function
REQ-014 Prescaler counts 0..DIV-1 and wraps; it runs only in SHOW/GAP and is held at 0 in IDLE.
REQ-015 FSM states: IDLE, SHOW, GAP.
- IDLE->SHOW when en=1.
- SHOW->GAP when prescaler = DIV-GAP-1.
- GAP->SHOW when prescaler = DIV-1; digit index advances, wrapping NDIG-1->0.
- Any state->IDLE when en=0; index resets to 0.
REQ-016 In SHOW, dig_en = one-hot(index) and seg = decode(nibble[index]); in IDLE and GAP, dig_en = 0 and seg = 0.
REQ-017 Outputs are registered: the cycle after the state/index change is the first cycle the new seg/dig_en are visible.
REQ-018 Decode table (hex 0..F): 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47.
REQ-019 load stores data in a pending register and sets busy; a later load before commit overwrites pending.
REQ-020 Commit (pending->display register, busy cleared) happens only at frame boundaries: the GAP->SHOW transition with index NDIG-1, or the IDLE->SHOW transition; a commit is never made mid-frame, so there is no tearing.
REQ-021 load in the same cycle as a commit: the new data wins; it is committed directly and busy stays 0.
REQ-022 frame_done pulses in the cycle of the GAP->SHOW transition at index NDIG-1; it does not pulse when en drops mid-frame.
REQ-023 Leading-zero blanking, when blank_lz=1: digit i>0 has seg=0 if nibbles i..NDIG-1 of the display register are all 0; digit 0 is never blanked; dig_en is unaffected.
REQ-024 blank_lz and en are sampled every cycle with no latching.

Reset
REQ-025 On rst_n=0, immediately and asynchronously:
- state=IDLE, prescaler=0, index=0;
- display and pending registers=0;
- seg=0, dig_en=0, frame_done=0, busy=0.
REQ-026 Reset mid-frame discards the pending value; after release the block waits in IDLE for en=1.

Structure
REQ-027 A shared package holds the FSM state enum, the 16-entry segment constant table, and width helpers for index and prescaler.
REQ-028 Segment decode is one combinational sub-module, disp7s (4-bit in, 7-bit out), instantiated once on the selected nibble.

Verification
REQ-029 NDIG=4, DIV=4, GAP=1; reset; en=1; load data=16'h1234 -> dig_en 0001/0010/0100/1000 for 3 cycles each with 1 zero cycle between; seg 33,79,6D,30; frame_done once per 16 cycles.
REQ-030 blank_lz=1, data=16'h0005 -> digit0 seg=5B, digits 1..3 seg=0 with dig_en still scanning; data=16'h0000 -> digit0 seg=7E.
REQ-031 Mid-frame at index 1, load 16'hABCD -> busy=1; current frame finishes with the old value; next frame shows 3D,4E,1F,77; busy clears at the boundary.
REQ-032 load asserted exactly in the commit cycle with 16'hFFFF -> busy stays 0; next frame shows 47 on all digits.
REQ-033 en dropped at index 2 -> seg=0 and dig_en=0 next cycle, no frame_done; en re-raised -> scan restarts at digit 0.
REQ-034 rst_n pulsed low mid-SHOW between clock edges -> seg, dig_en, busy reach 0 without a clock edge; display register reads 0.
